// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and the prefetch FIFO entry type for the
//               instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // Default reset PC; memory addresses are expressed relative to it
  localparam logic [31:0] FETCH_PC_BASE = 32'h8002_0000;

  // Width of a MIPS instruction word and of the stored PC field
  localparam int FETCH_INSTR_W = 32;
  localparam int FETCH_ADDR_W  = 32;

  // Byte distance between consecutive instruction words
  localparam int FETCH_PC_INC = 4;

  // One prefetch FIFO slot: the instruction and the PC it was fetched from
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop,
//               flush, occupancy count, empty and full. The head entry is
//               presented combinationally; an empty FIFO after reset shows
//               {RST_PC, 0} at its head.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int                      DEPTH  = 4,
  parameter logic [FETCH_ADDR_W-1:0] RST_PC = FETCH_PC_BASE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  fetch_entry_t             push_entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic w_push;
  logic w_pop;

  // Protect the storage against misuse; the owner's credit scheme never
  // pushes into a full FIFO nor pops an empty one.
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; flush empties without touching data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: RST_PC, instr: '0};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Keeps the PC, issues word-aligned
//               memory reads under a credit limit (outstanding + buffered
//               <= DEPTH), buffers in-order responses in a prefetch FIFO and
//               hands {instr, pc} to decode. A redirect flushes the FIFO and
//               arranges for every still-outstanding response to be dropped.
//               ADDR_W and DATA_W must not exceed 32.
// Config      : FETCH_PERF_EN - when defined, instantiates the delivered
//               instruction and decode-stall counters; otherwise both
//               performance outputs read 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] PC_BASE = ADDR_W'(FETCH_PC_BASE),
  parameter int                DEPTH   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_data_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
);

  localparam int                CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(FETCH_PC_INC);

  // Requests are held off for the first cycle out of reset
  logic              started_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
  logic [CNT_W-1:0]  outst_q,    outst_d;
  logic [CNT_W-1:0]  drop_q,     drop_d;

  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_req_fire;
  logic              w_resp_ok;
  logic              w_credit;
  logic [CNT_W:0]    w_inflight;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head_entry;

  // Every request in flight owns a FIFO slot, so the FIFO cannot overflow
  assign w_inflight      = (CNT_W+1)'(outst_q) + (CNT_W+1)'(w_fifo_count);
  assign w_credit        = ~w_fifo_full & (w_inflight < (CNT_W+1)'(DEPTH));
  assign mem_req_valid_o = started_q & enable_i & ~redirect_valid_i & w_credit;
  assign mem_req_addr_o  = fetch_pc_q - PC_BASE;
  assign w_req_fire      = mem_req_valid_o & mem_req_ready_i;

  // A response with nothing outstanding is a protocol error and is ignored
  assign w_resp_ok     = mem_resp_valid_i & (outst_q != '0);
  assign w_redirect_pc = redirect_pc_i & ~ADDR_W'(3);

  // Decoder side; a pop coinciding with a redirect is cancelled by the flush
  assign instr_valid_o = ~w_fifo_empty;
  assign instr_data_o  = DATA_W'(w_head_entry.instr);
  assign instr_pc_o    = ADDR_W'(w_head_entry.pc);
  assign w_pop         = instr_valid_o & instr_ready_i & ~redirect_valid_i;
  assign w_push_entry  = '{pc: FETCH_ADDR_W'(resp_pc_q), instr: FETCH_INSTR_W'(mem_resp_data_i)};

  // PC, credit and drop bookkeeping; redirect overrides all other activity
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    w_push     = 1'b0;
    w_flush    = 1'b0;
    if (redirect_valid_i) begin
      fetch_pc_d = w_redirect_pc;
      resp_pc_d  = w_redirect_pc;
      outst_d    = outst_q - CNT_W'(w_resp_ok);
      drop_d     = outst_q - CNT_W'(w_resp_ok);
      w_flush    = 1'b1;
    end else begin
      if (w_req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_INC;
      end
      outst_d = outst_q + CNT_W'(w_req_fire) - CNT_W'(w_resp_ok);
      if (w_resp_ok) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          w_push    = 1'b1;
          resp_pc_d = resp_pc_q + PC_INC;
        end
      end
    end
  end

  // Fetch state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started_q  <= 1'b0;
      fetch_pc_q <= PC_BASE;
      resp_pc_q  <= PC_BASE;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      started_q  <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .RST_PC (FETCH_ADDR_W'(PC_BASE))
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .flush_i      (w_flush),
    .head_o       (w_head_entry),
    .count_o      (w_fifo_count),
    .empty_o      (w_fifo_empty),
    .full_o       (w_fifo_full)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Delivered-instruction and decode back-pressure counters, free-wrapping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (w_pop) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (instr_valid_o & ~instr_ready_i) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  assign perf_fetch_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire
